// File: rtl/isqrt_pkg.sv
// Shared definitions for the sequential integer square root block:
// FSM state encoding and the request-to-result latency helper.
package isqrt_pkg;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_busy = 2'd1,
    st_done = 2'd2
  } state_t;

  // Cycles from the accepting cycle to the y_vld cycle for radicand width n.
  function automatic int isqrt_latency(input int n);
    return n / 2 + 1;
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One digit-recurrence step of the restoring integer square root.
// Brings down the next two radicand bits, tries subtracting {root, 01}
// and appends the resulting root bit. Purely combinational.
module isqrt_step #(
  parameter int n = 32
) (
  input  logic [n/2+1:0] rem,
  input  logic [n/2-1:0] root,
  input  logic [1:0]     bits,
  output logic [n/2+1:0] rem_next,
  output logic [n/2-1:0] root_next
);

  localparam int h = n / 2;

  // Widened by two bits so the shift never drops anything; the
  // invariant rem <= 2*root keeps the true result within h+2 bits.
  logic [h+3:0] rem_sh_s;
  logic [h+3:0] trial_s;
  logic         ge_s;

  // Trial subtraction and root bit decision for this step.
  always_comb begin
    rem_sh_s = {rem, bits};
    trial_s  = {2'b00, root, 2'b01};
    ge_s     = (rem_sh_s >= trial_s);
    if (ge_s) begin
      rem_next  = (h + 2)'(rem_sh_s - trial_s);
      root_next = {root[h-2:0], 1'b1};
    end else begin
      rem_next  = (h + 2)'(rem_sh_s);
      root_next = {root[h-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/isqrt_seq_fsm.sv
// Sequential integer square root responder: accepts a radicand on x_vld,
// resolves one root bit per clock and pulses y_vld with floor(sqrt(x)).
// A new request is taken in the same cycle as y_vld so chained requests
// run back to back without a gap.
module isqrt_seq_fsm
  import isqrt_pkg::*;
#(
  parameter int n     = 32,
  parameter int cnt_w = $clog2(n / 2)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           x_vld,
  input  logic [n-1:0]   x,
  output logic           y_vld,
  output logic [n/2-1:0] y,
  output logic           busy
);

  localparam int h = n / 2;
  localparam logic [cnt_w-1:0] cnt_init = cnt_w'(h - 1);
  localparam logic [cnt_w-1:0] cnt_zero = {cnt_w{1'b0}};
  localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(1);

  state_t         state_r;
  state_t         state_next_s;
  logic [n-1:0]   x_sh_r;
  logic [h+1:0]   rem_r;
  logic [h-1:0]   root_r;
  logic [cnt_w-1:0] cnt_r;
  logic [h-1:0]   y_r;
  logic           y_vld_r;
  logic           busy_r;

  logic           accept_s;
  logic           last_iter_s;
  logic [h+1:0]   rem_next_s;
  logic [h-1:0]   root_next_s;

  isqrt_step #(.n(n)) u_step (
    .rem       (rem_r),
    .root      (root_r),
    .bits      (x_sh_r[n-1:n-2]),
    .rem_next  (rem_next_s),
    .root_next (root_next_s)
  );

  // Next-state decode plus the accept and final-iteration qualifiers.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    last_iter_s  = 1'b0;
    case (state_r)
      st_idle: begin
        accept_s     = x_vld;
        state_next_s = x_vld ? st_busy : st_idle;
      end
      st_busy: begin
        last_iter_s  = (cnt_r == cnt_zero);
        state_next_s = last_iter_s ? st_done : st_busy;
      end
      st_done: begin
        accept_s     = x_vld;
        state_next_s = x_vld ? st_busy : st_idle;
      end
      default: begin
        state_next_s = st_idle;
      end
    endcase
  end

  // State, datapath and registered outputs; x_vld while busy is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= st_idle;
      x_sh_r  <= {n{1'b0}};
      rem_r   <= {(h + 2){1'b0}};
      root_r  <= {h{1'b0}};
      cnt_r   <= cnt_zero;
      y_r     <= {h{1'b0}};
      y_vld_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      y_vld_r <= last_iter_s;
      busy_r  <= (state_next_s == st_busy);
      if (accept_s) begin
        x_sh_r <= x;
        rem_r  <= {(h + 2){1'b0}};
        root_r <= {h{1'b0}};
        cnt_r  <= cnt_init;
      end else if (state_r == st_busy) begin
        x_sh_r <= {x_sh_r[n-3:0], 2'b00};
        rem_r  <= rem_next_s;
        root_r <= root_next_s;
        cnt_r  <= cnt_r - cnt_one;
      end else begin
        x_sh_r <= x_sh_r;
        rem_r  <= rem_r;
        root_r <= root_r;
        cnt_r  <= cnt_r;
      end
      if (last_iter_s) begin
        y_r <= root_next_s;
      end else begin
        y_r <= y_r;
      end
    end
  end

  assign y_vld = y_vld_r;
  assign y     = y_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_isqrt_seq_fsm.sv
// Scoreboard bench for isqrt_seq_fsm: the driver pushes the expected root
// and due cycle for every accepted request; a monitor on the falling edge
// pops and compares whenever y_vld is seen, and also checks busy.
module tb_isqrt_seq_fsm;
  import isqrt_pkg::*;

  localparam int N   = 32;
  localparam int LAT = isqrt_latency(N);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           x_vld = 1'b0;
  logic [N-1:0]   x = '0;
  logic           y_vld;
  logic [N/2-1:0] y;
  logic           busy;

  typedef struct {
    logic [N-1:0]   x;
    logic [N/2-1:0] y;
    int             due;
  } exp_t;

  exp_t q[$];
  int cyc      = 0;
  int checks   = 0;
  int errors   = 0;
  int next_ok  = 0;
  int accepted = 0;
  int seen     = 0;

  isqrt_seq_fsm #(.n(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .x_vld (x_vld),
    .x     (x),
    .y_vld (y_vld),
    .y     (y),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Cycle index: cycle k is the period after the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: largest r with r*r <= v, by binary search.
  function automatic logic [N/2-1:0] ref_sqrt(input logic [N-1:0] v);
    longint lo = 0;
    longint hi = (longint'(1) << (N / 2)) - 1;
    longint mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(v)) lo = mid;
      else hi = mid - 1;
    end
    return lo[N/2-1:0];
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one request in the first cycle the block accepts it.
  task automatic send(input logic [N-1:0] v);
    exp_t e;
    while (cyc < next_ok) begin
      @(posedge clk); #1;
    end
    x_vld = 1'b1;
    x     = v;
    e.x   = v;
    e.y   = ref_sqrt(v);
    e.due = cyc + LAT;
    q.push_back(e);
    next_ok = cyc + LAT;
    accepted++;
    @(posedge clk); #1;
    x_vld = 1'b0;
    x     = $urandom;
  endtask

  // Monitor: compare results, latency and busy against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (y_vld) begin
        seen++;
        if (q.size() == 0) begin
          check("spurious_y_vld", 1, 0);
        end else begin
          check("y_value", y, q[0].y);
          check("y_latency", cyc, q[0].due);
          void'(q.pop_front());
        end
      end else if (q.size() > 0 && cyc >= q[0].due) begin
        check("y_vld_missing", 0, 1);
        void'(q.pop_front());
      end
      check("busy", busy,
            (q.size() > 0 && cyc > q[0].due - LAT && cyc < q[0].due) ? 1 : 0);
    end
  end

  initial begin
    logic [N-1:0] v;
    logic [N-1:0] singles [6];
    int k;
    int guard;
    singles[0] = 32'd1;
    singles[1] = 32'd15;
    singles[2] = 32'd16;
    singles[3] = 32'd1000000;
    singles[4] = 32'hFFFF_FFFF;
    singles[5] = 32'hFFFE_0001;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_y_vld", y_vld, 0);
    check("rst_y", y, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    next_ok = cyc;

    send(32'd0);
    for (int i = 0; i < 6; i++) begin
      next_ok = next_ok + 2;
      send(singles[i]);
    end

    // Chained: second request in the y_vld cycle of the first.
    next_ok = next_ok + 3;
    send(32'd81);
    send(32'd49);

    // x_vld during busy cycle 5 must be ignored.
    next_ok = next_ok + 2;
    send(32'd100);
    repeat (4) begin @(posedge clk); #1; end
    x_vld = 1'b1;
    x     = 32'd4;
    @(posedge clk); #1;
    x_vld = 1'b0;

    // Reset at busy cycle 8 discards the request.
    next_ok = next_ok + 2;
    send(32'd400);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    q.delete();
    accepted--;
    @(posedge clk); #1;
    rst = 1'b0;
    next_ok = cyc;
    send(32'd9);

    // Random traffic with chained requests and random idle gaps.
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(9, 0);
      case (k)
        0: v = '0;
        1: v = '1;
        2: begin v = $urandom_range(65535, 0); v = v * v; end
        3: begin v = $urandom_range(65535, 1); v = v * v - 1; end
        default: v = $urandom;
      endcase
      if ($urandom_range(1, 0) == 1) next_ok = next_ok + $urandom_range(5, 1);
      send(v);
    end

    guard = 0;
    while (q.size() > 0 && guard < 4 * LAT) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain", q.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
    check("y_vld_count", seen, accepted);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
